// File: rtl/db_stream_feeder.sv
// db_stream_feeder: paces 512-bit database words from the memory FIFO into the
// 2-bit/nucleotide shift stage, tracking window position and global offset.
module db_stream_feeder #(
  parameter int DATA_W      = 512,
  parameter int LEN_W       = 32,
  parameter int LOAD_AT     = 245,
  parameter int TAIL_SHIFTS = 245,
  parameter int STALL_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    dbLen,
  input  logic [DATA_W-1:0]   inData,
  input  logic                inValid,
  output logic                inReady,
  output logic [DATA_W-1:0]   outData,
  output logic                load,
  output logic                shift,
  output logic                dataValid,
  output logic [8:0]          ShiftNo,
  input  logic                stop,
  output logic [LEN_W+7:0]    dbPos,
  output logic                done
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | waiting for the first word of the pass
  // RUN   | shifting; next word is taken at ShiftNo == LOAD_AT-1
  // WAITW | at the load point with the FIFO empty
  // STALL | matcher stop in progress, returns to resume_st
  // TAIL  | final word loaded, finishing its plain shifts
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RUN, S_WAITW, S_STALL, S_TAIL, S_DONE
  } state_t;

  localparam logic [7:0]       STALL_LOAD = 8'(STALL_CYC - 1);
  localparam logic [LEN_W+7:0] POS_ONE    = (LEN_W+8)'(1);

  state_t           state, state_nxt, resume_st, stall_dst;
  logic [LEN_W-1:0] words_left;
  logic [7:0]       stall_cnt;
  logic             at_load_pt, have_words, xfer, shift_nxt, stall_go;

  assign at_load_pt = (ShiftNo == 9'(LOAD_AT - 1));
  assign have_words = (words_left != '0);
  assign xfer       = inValid & inReady;
  assign stall_go   = stop & ((state == S_RUN) | (state == S_WAITW) |
                              (state == S_TAIL) | (state == S_STALL));
  // a single-cycle stall needs no STALL visit: the stop cycle itself is the stall
  assign stall_dst  = (STALL_CYC > 1) ? S_STALL : state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (dbLen == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (xfer) state_nxt = S_RUN;
      S_RUN: begin
        if (stop) state_nxt = stall_dst;
        else if (at_load_pt) begin
          if (!have_words) state_nxt = S_TAIL;
          else if (!xfer)  state_nxt = S_WAITW;
        end
      end
      S_WAITW: begin
        if (stop)      state_nxt = stall_dst;
        else if (xfer) state_nxt = S_RUN;
      end
      S_TAIL: begin
        if (stop)                               state_nxt = stall_dst;
        else if (ShiftNo >= 9'(TAIL_SHIFTS))    state_nxt = S_DONE;
      end
      S_STALL: if (!stop && stall_cnt == 8'd1) state_nxt = resume_st;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inReady   = 1'b0;
    shift_nxt = 1'b0;
    if (have_words && !stop)
      inReady = (state == S_FETCH) || (state == S_WAITW) ||
                ((state == S_RUN) && at_load_pt);
    case (state)
      S_RUN:   shift_nxt = !stop && !(at_load_pt && have_words && !xfer);
      S_WAITW: shift_nxt = xfer;
      S_TAIL:  shift_nxt = !stop && (ShiftNo < 9'(TAIL_SHIFTS));
      default: shift_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outData    <= '0;
      load       <= 1'b0;
      shift      <= 1'b0;
      dataValid  <= 1'b0;
      done       <= 1'b0;
      ShiftNo    <= '0;
      dbPos      <= '0;
      words_left <= '0;
      stall_cnt  <= '0;
      resume_st  <= S_IDLE;
    end else begin
      load      <= xfer;
      dataValid <= xfer;
      shift     <= shift_nxt;
      done      <= (state_nxt == S_DONE);
      if (xfer) outData <= inData;

      if (state == S_IDLE && start) words_left <= dbLen;
      else if (xfer)                words_left <= words_left - LEN_W'(1);

      if (xfer)           ShiftNo <= '0;
      else if (shift_nxt) ShiftNo <= ShiftNo + 9'd1;

      if (state == S_IDLE && start) dbPos <= '0;
      else if (shift_nxt)           dbPos <= dbPos + POS_ONE;

      // stop during STALL reloads the timer so the stall restarts
      if (stall_go)               stall_cnt <= STALL_LOAD;
      else if (state == S_STALL)  stall_cnt <= stall_cnt - 8'd1;
      if (stall_go && state != S_STALL) resume_st <= state;
    end
  end

endmodule

// File: tb/tb_db_stream_feeder.sv
// Bench for db_stream_feeder: directed scenarios plus randomized FIFO/stop traffic,
// checked cycle by cycle against a nucleotide-count level model.
module tb_db_stream_feeder;
  localparam int DATA_W      = 512;
  localparam int LEN_W       = 32;
  localparam int LOAD_AT     = 245;
  localparam int TAIL_SHIFTS = 245;
  localparam int STALL_CYC   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  dbLen = '0;
  logic [DATA_W-1:0] inData = '0;
  logic              inValid = 1'b0;
  logic              stop = 1'b0;
  logic              inReady, load, shift, dataValid, done;
  logic [DATA_W-1:0] outData;
  logic [8:0]        ShiftNo;
  logic [LEN_W+7:0]  dbPos;

  always #5 clk = ~clk;

  db_stream_feeder #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .LOAD_AT(LOAD_AT),
    .TAIL_SHIFTS(TAIL_SHIFTS), .STALL_CYC(STALL_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dbLen(dbLen),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .outData(outData), .load(load), .shift(shift), .dataValid(dataValid),
    .ShiftNo(ShiftNo), .stop(stop), .dbPos(dbPos), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: pass phase plus nucleotide counts
  typedef enum {M_IDLE, M_FETCH, M_FEED, M_DONE} mphase_t;
  mphase_t           ph;
  int                words, since, total, stall_left;
  logic              exp_load, exp_shift, exp_done;
  logic [DATA_W-1:0] exp_out;
  int                n_load, n_shift, n_done;

  task automatic reset_model();
    ph = M_IDLE; words = 0; since = 0; total = 0; stall_left = 0;
    exp_load = 0; exp_shift = 0; exp_done = 0; exp_out = '0;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic model_step();
    bit rdy, xf;
    rdy = !stop && words > 0 &&
          (ph == M_FETCH || (ph == M_FEED && stall_left == 0 && since == LOAD_AT-1));
    chk("inReady", inReady, rdy);
    xf = inValid && rdy;
    exp_load = 0; exp_shift = 0; exp_done = 0;
    case (ph)
      M_IDLE: if (start) begin
        words = int'(dbLen); total = 0;
        if (dbLen == 0) begin ph = M_DONE; exp_done = 1; end
        else ph = M_FETCH;
      end
      M_FETCH: if (xf) begin
        exp_load = 1; exp_out = inData; since = 0; words--; ph = M_FEED;
      end
      M_FEED: begin
        if (stop) stall_left = STALL_CYC - 1;
        else if (stall_left > 0) stall_left--;
        else if (since == LOAD_AT-1 && words > 0) begin
          if (xf) begin
            exp_load = 1; exp_shift = 1; exp_out = inData;
            since = 0; total++; words--;
          end
        end else if (words > 0 || since < TAIL_SHIFTS) begin
          exp_shift = 1; since++; total++;
        end else begin
          exp_done = 1; ph = M_DONE;
        end
      end
      M_DONE: ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
  endtask

  // inputs are set just after a falling edge; one call spans one rising edge
  task automatic tick();
    #1;
    model_step();
    @(negedge clk);
    chk("load", load, exp_load);
    chk("dataValid", dataValid, exp_load);
    chk("shift", shift, exp_shift);
    chk("done", done, exp_done);
    chk("ShiftNo", ShiftNo, since);
    chk("dbPos", dbPos, total);
    chk("outData", outData, exp_out);
    if (load)  n_load++;
    if (shift) n_shift++;
    if (done)  n_done++;
  endtask

  // mode: 0 plain, 1 FIFO gap at load point, 2 stop at ShiftNo 100,
  //       3 reset at ShiftNo 50, 4 random traffic with stray start/dbLen
  task automatic run_pass(input int len, input int vpct, input int spct,
                          input int mode, input string name);
    int cyc = 0, drop_left = 0, gap = 0;
    bit fired = 0, watch = 0;
    n_load = 0; n_shift = 0; n_done = 0;
    dbLen = LEN_W'(len); start = 1; inValid = 0; stop = 0;
    tick();
    start = 0;
    while (ph != M_IDLE && cyc < 20000) begin
      inData  = rand_word();
      inValid = ($urandom_range(99) < vpct);
      stop    = ($urandom_range(99) < spct);
      if (mode == 4) begin
        start = ($urandom_range(99) < 2);
        dbLen = $urandom();
      end
      if (mode == 1 && !fired && ph == M_FEED && since == LOAD_AT-1 && words > 0) begin
        fired = 1; drop_left = 10; watch = 1; gap = 0;
      end
      if (drop_left > 0) begin inValid = 0; drop_left--; end
      if (mode == 2 && !fired && ph == M_FEED && since == 100) begin
        fired = 1; stop = 1; watch = 1; gap = 0;
      end
      if (mode == 3 && !fired && ph == M_FEED && since == 50) begin
        #2 rst = 0;
        #1;
        chk("rst_load", load, 0);
        chk("rst_shift", shift, 0);
        chk("rst_dataValid", dataValid, 0);
        chk("rst_done", done, 0);
        chk("rst_inReady", inReady, 0);
        chk("rst_ShiftNo", ShiftNo, 0);
        chk("rst_dbPos", dbPos, 0);
        chk("rst_outData", outData, 0);
        repeat (2) begin
          @(negedge clk);
          chk("rst_hold_done", done, 0);
          chk("rst_hold_load", load, 0);
        end
        chk("rst_no_done_seen", n_done, 0);
        reset_model();
        inValid = 0; stop = 0;
        rst = 1;
        return;
      end
      tick();
      cyc++;
      if (watch) begin
        if (!load && !shift) begin
          gap++;
          if (mode == 2) chk("stall_hold_ShiftNo", ShiftNo, 100);
        end else begin
          watch = 0;
          if (mode == 1) begin
            chk("waitw_idle_cycles", gap, 10);
            chk("waitw_combined_load", load, 1);
          end else begin
            chk("stall_idle_cycles", gap, STALL_CYC);
            chk("stall_resume_ShiftNo", ShiftNo, 101);
          end
        end
      end
    end
    start = 0; inValid = 0; stop = 0;
    if (cyc >= 20000) chk({name, "_timeout"}, 1, 0);
    if (mode == 1 || mode == 2) chk({name, "_scenario_hit"}, fired, 1);
    chk({name, "_loads"}, n_load, len);
    chk({name, "_shifts"}, n_shift, (len == 0) ? 0 : LOAD_AT*(len-1) + TAIL_SHIFTS);
    chk({name, "_dbPos"}, dbPos, (len == 0) ? 0 : LOAD_AT*(len-1) + TAIL_SHIFTS);
    chk({name, "_done_count"}, n_done, 1);
    if (len > 0) chk({name, "_final_ShiftNo"}, ShiftNo, TAIL_SHIFTS);
  endtask

  initial begin
    reset_model();
    #2;
    chk("init_load", load, 0);
    chk("init_shift", shift, 0);
    chk("init_done", done, 0);
    chk("init_inReady", inReady, 0);
    chk("init_dbPos", dbPos, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    run_pass(1, 100, 0, 0, "len1");
    run_pass(2, 100, 0, 0, "len2");
    run_pass(2, 100, 0, 1, "fifo_gap");
    run_pass(1, 100, 0, 2, "stop_pulse");
    run_pass(0, 100, 0, 0, "len0");
    run_pass(3, 100, 0, 3, "mid_reset");
    run_pass(1, 100, 0, 0, "after_reset");
    for (int i = 0; i < 6; i++)
      run_pass($urandom_range(1, 3), $urandom_range(40, 100), $urandom_range(0, 8), 4, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
